// File: rtl/aemb_intc_pkg.sv
// Shared constants and types for the AEMB interrupt controller.
package aemb_intc_pkg;

  // Word offsets within the register window (byte address bits [3:2]).
  localparam logic [1:0] ADR_ISR = 2'd0;
  localparam logic [1:0] ADR_IER = 2'd1;
  localparam logic [1:0] ADR_IVR = 2'd2;
  localparam logic [1:0] ADR_MER = 2'd3;

  // IVR value when no enabled source is pending.
  localparam logic [31:0] IVR_NONE = 32'hFFFF_FFFF;

  // Clocks the request line is held low after an acknowledge so the
  // downstream edge latch always sees a fresh rising edge.
  localparam int unsigned REARM_GAP = 2;

  typedef enum logic {
    StIdle,
    StRearm
  } intcState_e;

endpackage

// File: rtl/aemb_intc_sync.sv
// Single-bit input conditioner: two-flop synchroniser plus a history flop
// so the caller gets both the clean level and a one-clock rising-edge pulse.
module aemb_intc_sync (
  input  logic gclk,
  input  logic grst,
  input  logic irqRaw,
  output logic irqSync,
  output logic irqEdge
);

  logic metaQ;
  logic syncQ;
  logic histQ;

  // Synchroniser chain followed by the history stage used for edge detect.
  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      metaQ <= 1'b0;
      syncQ <= 1'b0;
      histQ <= 1'b0;
    end else begin
      metaQ <= irqRaw;
      syncQ <= metaQ;
      histQ <= syncQ;
    end
  end

  assign irqSync = syncQ;
  assign irqEdge = syncQ & ~histQ;

endmodule

// File: rtl/aemb_intc.sv
// Wishbone-slave interrupt controller feeding the control unit's sys_int_i.
// Latches edge/level sources into ISR, masks with IER/MER, exposes a
// lowest-index priority vector and re-arms the output after every ack so a
// still-pending source produces a new rising edge.
module aemb_intc
  import aemb_intc_pkg::*;
#(
  parameter int unsigned         IRQN    = 8,
  parameter logic [IRQN-1:0]     IRQEDGE = {IRQN{1'b1}}
) (
  input  logic            sys_clk_i,
  input  logic            sys_rst_i,
  input  logic [IRQN-1:0] irq_i,
  input  logic            wb_stb_i,
  input  logic            wb_we_i,
  input  logic [1:0]      wb_adr_i,
  input  logic [31:0]     wb_dat_i,
  output logic [31:0]     wb_dat_o,
  output logic            wb_ack_o,
  output logic            sys_int_o
);

  logic [IRQN-1:0] irqSync;
  logic [IRQN-1:0] irqEdge;

  logic [IRQN-1:0] isrQ;
  logic [IRQN-1:0] isrD;
  logic [IRQN-1:0] ierQ;
  logic [IRQN-1:0] ierD;
  logic            merQ;
  logic            merD;

  logic            access;
  logic            wrIsr;
  logic            wrIer;
  logic            wrMer;
  logic [IRQN-1:0] w1c;
  logic            reqNow;
  logic            reqNext;
  logic            rearmHit;
  logic [31:0]     ivr;
  logic [31:0]     rdData;

  intcState_e      stateQ;
  logic [1:0]      rearmCntQ;

  // Bits above IRQN-1 are write-ignored by design.
  logic            unusedDat;
  assign unusedDat = ^wb_dat_i;

  // One conditioner per source.
  for (genvar i = 0; i < int'(IRQN); i++) begin : gSync
    aemb_intc_sync uSync (
      .gclk    (sys_clk_i),
      .grst    (sys_rst_i),
      .irqRaw  (irq_i[i]),
      .irqSync (irqSync[i]),
      .irqEdge (irqEdge[i])
    );
  end

  // Lowest set index wins; IVR_NONE when the vector is empty.
  function automatic logic [31:0] lowestSet(input logic [IRQN-1:0] vec);
    logic [31:0] idx;
    idx = IVR_NONE;
    for (int i = int'(IRQN) - 1; i >= 0; i--) begin
      if (vec[i]) idx = 32'(i);
    end
    return idx;
  endfunction

  // Decode the single-wait-state bus access and compute next register state.
  always_comb begin
    access = wb_stb_i & ~wb_ack_o;
    wrIsr  = access & wb_we_i & (wb_adr_i == ADR_ISR);
    wrIer  = access & wb_we_i & (wb_adr_i == ADR_IER);
    wrMer  = access & wb_we_i & (wb_adr_i == ADR_MER);
    w1c    = wrIsr ? wb_dat_i[IRQN-1:0] : '0;
    // Edge bits: set beats clear. Level bits simply follow the input.
    isrD   = (IRQEDGE & ((isrQ & ~w1c) | irqEdge)) | (~IRQEDGE & irqSync);
    ierD   = wrIer ? wb_dat_i[IRQN-1:0] : ierQ;
    merD   = wrMer ? wb_dat_i[0] : merQ;
    reqNow   = merQ & (|(isrQ & ierQ));
    reqNext  = merD & (|(isrD & ierD));
    rearmHit = (wrIsr | wrIer | wrMer) & reqNext;
    ivr      = lowestSet(isrQ & ierQ);
  end

  // Read data multiplexer.
  always_comb begin
    rdData = '0;
    unique case (wb_adr_i)
      ADR_ISR: rdData = 32'(isrQ);
      ADR_IER: rdData = 32'(ierQ);
      ADR_IVR: rdData = ivr;
      ADR_MER: rdData = {31'b0, merQ};
    endcase
  end

  // Pending, enable and master-enable registers.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      isrQ <= '0;
      ierQ <= '0;
      merQ <= 1'b0;
    end else begin
      isrQ <= isrD;
      ierQ <= ierD;
      merQ <= merD;
    end
  end

  // Bus handshake: ack every access after one wait state, register read data.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= wb_stb_i & ~wb_ack_o;
      if (access) begin
        wb_dat_o <= wb_we_i ? 32'b0 : rdData;
      end
    end
  end

  // Output FSM: registered request, forced low for REARM_GAP clocks after
  // any acknowledge-type write that leaves a request standing.
  always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
    if (!sys_rst_i) begin
      stateQ    <= StIdle;
      rearmCntQ <= '0;
      sys_int_o <= 1'b0;
    end else begin
      case (stateQ)
        StIdle: begin
          if (rearmHit) begin
            stateQ    <= StRearm;
            rearmCntQ <= 2'(REARM_GAP - 1);
            sys_int_o <= 1'b0;
          end else begin
            sys_int_o <= reqNow;
          end
        end
        StRearm: begin
          if (rearmHit) begin
            rearmCntQ <= 2'(REARM_GAP - 1);
            sys_int_o <= 1'b0;
          end else if (rearmCntQ == 2'd0) begin
            stateQ    <= StIdle;
            sys_int_o <= reqNow;
          end else begin
            rearmCntQ <= rearmCntQ - 2'd1;
            sys_int_o <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule
